// File: rtl/bcd_cascade_counter_pkg.sv
// Shared constants for the cascaded modulo counter and its digit cells.
package bcd_cascade_counter_pkg;

    // Direction encoding on iDir.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Value every wrap/error flag takes after reset or clear.
    localparam logic FLAG_RESET = 1'b0;

    // Legal range of the digit count for a single-cycle carry chain.
    localparam int DIGITS_MIN = 1;
    localparam int DIGITS_MAX = 8;

endpackage

// File: rtl/bcd_digit_cell.sv
// One modulo-MOD digit: load with clamping, up/down step with wrap,
// terminal-value indication for the carry chain and a registered wrap pulse.
module bcd_digit_cell
    import bcd_cascade_counter_pkg::*;
#(
    parameter int MOD = 10,
    parameter int DW  = 4
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iClr,
    input  logic          iLoad,
    input  logic [DW-1:0] iLoadDigit,
    input  logic          iStep,
    input  logic          iDir,
    output logic [DW-1:0] oDigit,
    output logic          oTerminal,
    output logic          oWrap,
    output logic          oClamp
);

    localparam int            DWP1       = DW + 1;
    localparam logic [DW-1:0] DIGIT_MAX  = DW'(MOD - 1);
    localparam logic [DW-1:0] DIGIT_ZERO = '0;
    localparam logic [DW-1:0] DIGIT_ONE  = DW'(1);
    localparam logic [DW:0]   MOD_WIDE   = DWP1'(MOD);

    logic [DW-1:0] r_digit;
    logic          r_wrap;
    logic          w_up;
    logic [DW-1:0] w_next;
    logic [DW-1:0] w_loadVal;

    assign w_up = (iDir == DIR_UP);

    // The terminal value depends on direction: the digit that is about to wrap.
    assign oTerminal = w_up ? (r_digit == DIGIT_MAX) : (r_digit == DIGIT_ZERO);

    // Compare one bit wider so MOD == 2^DW never clamps anything.
    assign oClamp    = ({1'b0, iLoadDigit} >= MOD_WIDE);
    assign w_loadVal = oClamp ? DIGIT_MAX : iLoadDigit;

    // Next digit value for one step; wraps are handled before any add or
    // subtract so the arithmetic never leaves the 0..MOD-1 range.
    always_comb begin
        w_next = r_digit;
        if (oTerminal) begin
            w_next = w_up ? DIGIT_ZERO : DIGIT_MAX;
        end else if (w_up) begin
            w_next = r_digit + DIGIT_ONE;
        end else begin
            w_next = r_digit - DIGIT_ONE;
        end
    end

    // Digit register and wrap pulse, priority reset > clear > load > step > hold.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_digit <= DIGIT_ZERO;
            r_wrap  <= FLAG_RESET;
        end else if (iClr) begin
            r_digit <= DIGIT_ZERO;
            r_wrap  <= FLAG_RESET;
        end else if (iLoad) begin
            r_digit <= w_loadVal;
            r_wrap  <= FLAG_RESET;
        end else if (iStep) begin
            r_digit <= w_next;
            r_wrap  <= oTerminal;
        end else begin
            r_wrap  <= FLAG_RESET;
        end
    end

    assign oDigit = r_digit;
    assign oWrap  = r_wrap;

endmodule

// File: rtl/bcd_cascade_counter.sv
// Multi-digit up/down modulo counter built from a chain of digit cells,
// with registered whole-counter wrap and load-clamp flags.
module bcd_cascade_counter
    import bcd_cascade_counter_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int MOD    = 10,
    parameter int DW     = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iEn,
    input  logic                 iDir,
    input  logic                 iClr,
    input  logic                 iLoad,
    input  logic [DIGITS*DW-1:0] iD,
    output logic [DIGITS*DW-1:0] oS,
    output logic                 oFlag,
    output logic [DIGITS-1:0]    oDigitWrap,
    output logic                 oLoadErr
);

    // Reject parameter sets the digit cells cannot represent.
    if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : gDigitsCheck
        $error("bcd_cascade_counter: DIGITS must be in 1..8");
    end
    if (MOD < 2) begin : gModMinCheck
        $error("bcd_cascade_counter: MOD must be at least 2");
    end
    if (DW < 1 || DW > 30 || MOD > (1 << DW)) begin : gModMaxCheck
        $error("bcd_cascade_counter: MOD must not exceed 2^DW");
    end

    logic [DIGITS:0]   w_carry;
    logic [DIGITS-1:0] w_term;
    logic [DIGITS-1:0] w_step;
    logic [DIGITS-1:0] w_clamp;
    logic [DIGITS-1:0] w_digitWrap;
    logic              r_flag;
    logic              r_loadErr;

    // Digit 0 always sees a carry; digit k sees one only if all lower digits
    // sit at their terminal value.
    assign w_carry[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : gDigit
        assign w_carry[k+1] = w_carry[k] & w_term[k];
        assign w_step[k]    = iEn & w_carry[k];

        bcd_digit_cell #(
            .MOD (MOD),
            .DW  (DW)
        ) uCell (
            .iClk       (iClk),
            .iRst       (iRst),
            .iClr       (iClr),
            .iLoad      (iLoad),
            .iLoadDigit (iD[k*DW +: DW]),
            .iStep      (w_step[k]),
            .iDir       (iDir),
            .oDigit     (oS[k*DW +: DW]),
            .oTerminal  (w_term[k]),
            .oWrap      (w_digitWrap[k]),
            .oClamp     (w_clamp[k])
        );
    end

    // Whole-counter wrap and load-clamp pulses, aligned with the digit registers.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_flag    <= FLAG_RESET;
            r_loadErr <= FLAG_RESET;
        end else if (iClr) begin
            r_flag    <= FLAG_RESET;
            r_loadErr <= FLAG_RESET;
        end else if (iLoad) begin
            r_flag    <= FLAG_RESET;
            r_loadErr <= |w_clamp;
        end else begin
            r_flag    <= iEn & w_carry[DIGITS];
            r_loadErr <= FLAG_RESET;
        end
    end

    assign oDigitWrap = w_digitWrap;
    assign oFlag      = r_flag;
    assign oLoadErr   = r_loadErr;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Randomised and directed bench for bcd_cascade_counter (2 digits, mod 10),
// compared against an integer-valued reference model.
module tb_bcd_cascade_counter;

    localparam int DIGITS = 2;
    localparam int MOD    = 10;
    localparam int DW     = 4;
    localparam int TOTAL  = MOD ** DIGITS;

    logic                 iClk;
    logic                 iRst;
    logic                 iEn;
    logic                 iDir;
    logic                 iClr;
    logic                 iLoad;
    logic [DIGITS*DW-1:0] iD;
    logic [DIGITS*DW-1:0] oS;
    logic                 oFlag;
    logic [DIGITS-1:0]    oDigitWrap;
    logic                 oLoadErr;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: whole counter as one integer 0..TOTAL-1.
    int                mValue;
    logic              mFlag;
    logic [DIGITS-1:0] mWrap;
    logic              mErr;

    bcd_cascade_counter #(
        .DIGITS (DIGITS),
        .MOD    (MOD),
        .DW     (DW)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iEn        (iEn),
        .iDir       (iDir),
        .iClr       (iClr),
        .iLoad      (iLoad),
        .iD         (iD),
        .oS         (oS),
        .oFlag      (oFlag),
        .oDigitWrap (oDigitWrap),
        .oLoadErr   (oLoadErr)
    );

    // Free-running 100 MHz clock.
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pack the model integer into per-digit fields.
    function automatic logic [DIGITS*DW-1:0] modelDigits(input int value);
        logic [DIGITS*DW-1:0] packed_s;
        packed_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            packed_s[k*DW +: DW] = DW'((value / (MOD ** k)) % MOD);
        end
        return packed_s;
    endfunction

    // Advance the reference model by one clock edge.
    task automatic modelStep(input logic clr, input logic load, input logic en,
                             input logic dir, input logic [DIGITS*DW-1:0] d);
        int dg;
        int p;
        mFlag = 1'b0;
        mWrap = '0;
        mErr  = 1'b0;
        if (clr) begin
            mValue = 0;
        end else if (load) begin
            mValue = 0;
            for (int k = 0; k < DIGITS; k++) begin
                dg = int'(d[k*DW +: DW]);
                if (dg >= MOD) begin
                    dg   = MOD - 1;
                    mErr = 1'b1;
                end
                mValue += dg * (MOD ** k);
            end
        end else if (en) begin
            for (int k = 0; k < DIGITS; k++) begin
                p = MOD ** (k + 1);
                mWrap[k] = dir ? ((mValue % p) == p - 1) : ((mValue % p) == 0);
            end
            mFlag  = dir ? (mValue == TOTAL - 1) : (mValue == 0);
            mValue = dir ? (mValue + 1) % TOTAL : (mValue + TOTAL - 1) % TOTAL;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_s"},    32'(oS),         32'(modelDigits(mValue)));
        checkOutput({tag, "_flag"}, 32'(oFlag),      32'(mFlag));
        checkOutput({tag, "_wrap"}, 32'(oDigitWrap), 32'(mWrap));
        checkOutput({tag, "_err"},  32'(oLoadErr),   32'(mErr));
    endtask

    // Drive one cycle of inputs, clock it, then compare DUT with the model.
    task automatic applyStimulus(input string tag, input logic clr, input logic load,
                                 input logic en, input logic dir,
                                 input logic [DIGITS*DW-1:0] d);
        iClr  = clr;
        iLoad = load;
        iEn   = en;
        iDir  = dir;
        iD    = d;
        @(posedge iClk);
        #1;
        modelStep(clr, load, en, dir, d);
        checkAll(tag);
    endtask

    initial begin
        iRst  = 1'b0;
        iEn   = 1'b0;
        iDir  = 1'b1;
        iClr  = 1'b0;
        iLoad = 1'b0;
        iD    = '0;
        mValue = 0;
        mFlag  = 1'b0;
        mWrap  = '0;
        mErr   = 1'b0;

        #12;
        checkAll("reset");
        #4;
        iRst = 1'b1;

        // Up wrap through 99 -> 00.
        applyStimulus("upLoad", 1'b0, 1'b1, 1'b0, 1'b1, 8'h98);
        applyStimulus("up99",   1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("up99_lit", 32'(oS), 32'h99);
        applyStimulus("up00",   1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("up00_lit", 32'(oS), 32'h00);
        checkOutput("up00_flag_lit", 32'(oFlag), 32'h1);
        checkOutput("up00_wrap_lit", 32'(oDigitWrap), 32'h3);
        applyStimulus("upHold", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Down wrap of the low digit only.
        applyStimulus("dnLoad", 1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        applyStimulus("dn09",   1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("dn09_wrap_lit", 32'(oDigitWrap), 32'h1);
        applyStimulus("dn08",   1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("dn08_lit", 32'(oS), 32'h08);

        // Full down wrap 00 -> 99.
        applyStimulus("fdLoad", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus("fd99",   1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("fd99_flag_lit", 32'(oFlag), 32'h1);

        // Priority: load over count, clear over load.
        applyStimulus("prLoad", 1'b0, 1'b1, 1'b1, 1'b1, 8'h42);
        checkOutput("prLoad_lit", 32'(oS), 32'h42);
        applyStimulus("prClr",  1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);

        // Clamp of an out-of-range digit.
        applyStimulus("clamp",     1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
        checkOutput("clamp_lit", 32'(oS), 32'h39);
        applyStimulus("clampHold", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Async reset mid-count.
        applyStimulus("arClr", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 37; i++) begin
            applyStimulus("arCount", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        end
        checkOutput("ar37_lit", 32'(oS), 32'h37);
        #2;
        iRst = 1'b0;
        #1;
        mValue = 0;
        mFlag  = 1'b0;
        mWrap  = '0;
        mErr   = 1'b0;
        checkAll("arAsync");
        #2;
        iRst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus("arIdle", 1'b0, 1'b0, 1'b0, 1'(i % 2), 8'h00);
        end

        // Randomised traffic, including out-of-range load digits.
        for (int i = 0; i < 400; i++) begin
            logic rClr;
            logic rLoad;
            logic rEn;
            logic rDir;
            logic [DIGITS*DW-1:0] rD;
            rClr  = ($urandom_range(0, 29) == 0);
            rLoad = ($urandom_range(0, 11) == 0);
            rEn   = ($urandom_range(0, 3) != 0);
            rDir  = ($urandom_range(0, 7) < 5);
            rD    = (DIGITS*DW)'($urandom);
            applyStimulus("rand", rClr, rLoad, rEn, rDir, rD);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
